// File: rtl/run_pattern_tx.sv
// run_pattern_tx
//   Serial stimulus source for the four-in-a-row run detector. It shifts a
//   latched pattern onto w one bit per clock, LSB first. Alongside the bits
//   it produces z_exp, the detector output expected for the stream sent so
//   far.
//
// Parameters
//   WIDTH     pattern register width
//   LEN_W     width of length / bit_idx (2**LEN_W must exceed WIDTH)
//
// Ports
//   Clock      in   rising-edge clock
//   Resetn     in   asynchronous active-low reset
//   start      in   begin transmission (sampled in IDLE only)
//   pattern    in   bits to send, latched on accepted start
//   length     in   bits to send; 0 or >WIDTH is clamped to WIDTH
//   repeat_en  in   wrap the pattern continuously until abort
//   abort      in   return to IDLE at the next edge (any state)
//   w          out  serial data bit
//   w_valid    out  w carries a pattern bit
//   busy       out  high in SEND and DONE
//   done       out  one-cycle pulse after the last bit of a non-repeating run
//   z_exp      out  expected detector output
//   bit_idx    out  index of the bit currently on w
module run_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             z_exp,
  output logic [LEN_W-1:0] bit_idx
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rep_q, rep_d;
  logic [LEN_W-1:0] idx_d;
  logic             w_d, wv_d, busy_d, done_d, z_d;
  // run tracker: previous bit and saturating run count (0 = no bit yet)
  logic             prev_q, prev_d;
  logic [2:0]       cnt_q, cnt_d;

  logic [LEN_W-1:0] len_clamp;
  logic [WIDTH-1:0] sh;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      bit_idx <= '0;
      w       <= 1'b0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      z_exp   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      bit_idx <= idx_d;
      w       <= w_d;
      w_valid <= wv_d;
      busy    <= busy_d;
      done    <= done_d;
      z_exp   <= z_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    idx_d     = bit_idx;
    w_d       = 1'b0;
    wv_d      = 1'b0;
    done_d    = 1'b0;
    z_d       = 1'b0;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    sh        = pat_q;
    len_clamp = (length == '0 || length > WIDTH_L) ? WIDTH_L : length;

    // Tracker consumes the bit currently on w; z_exp follows one cycle later,
    // mirroring a detector that samples w at this same edge.
    if (w_valid) begin
      prev_d = w;
      if (cnt_q == 3'd0 || w != prev_q) cnt_d = 3'd1;
      else if (cnt_q != 3'd4)           cnt_d = cnt_q + 3'd1;
      z_d = (cnt_d == 3'd4);
    end

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start && !abort) begin
          pat_d   = pattern;
          len_d   = len_clamp;
          rep_d   = repeat_en;
          prev_d  = 1'b0;
          cnt_d   = 3'd0;
          w_d     = pattern[0];
          wv_d    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_idx == len_q - LEN_W'(1)) begin
          idx_d = '0;
          if (rep_q) begin
            // wrap without touching the tracker: the stream is continuous
            w_d  = pat_q[0];
            wv_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          idx_d = bit_idx + LEN_W'(1);
          sh    = pat_q >> idx_d;
          w_d   = sh[0];
          wv_d  = 1'b1;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = '0;
      w_d     = 1'b0;
      wv_d    = 1'b0;
      done_d  = 1'b0;
      z_d     = 1'b0;
      prev_d  = 1'b0;
      cnt_d   = 3'd0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
module tb_run_pattern_tx;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        repeat_en = 1'b0;
  logic        abort = 1'b0;
  logic        w, w_valid, busy, done, z_exp;
  logic [4:0]  bit_idx;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       w;
    logic       wv;
    logic       busy;
    logic       done;
    logic       z;
    logic [4:0] idx;
  } obs_t;

  obs_t q[$];

  run_pattern_tx #(.WIDTH(16), .LEN_W(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .pattern(pattern),
    .length(length), .repeat_en(repeat_en), .abort(abort), .w(w),
    .w_valid(w_valid), .busy(busy), .done(done), .z_exp(z_exp),
    .bit_idx(bit_idx)
  );

  always #5 Clock = ~Clock;

  function automatic obs_t sample();
    obs_t o;
    o.w = w; o.wv = w_valid; o.busy = busy; o.done = done;
    o.z = z_exp; o.idx = bit_idx;
    return o;
  endfunction

  // Expected observation for cycles 1..ncyc after the accepting edge.
  // ab != 0: abort is asserted during cycle ab.
  task automatic push_run(input logic [15:0] p, input int len_in,
                          input bit rep, input int ncyc, input int ab);
    int L;
    obs_t e;
    L = (len_in == 0 || len_in > 16) ? 16 : len_in;
    for (int c = 1; c <= ncyc; c++) begin
      bit eq;
      e = '0;
      eq = 1'b1;
      if (!(ab != 0 && c > ab)) begin
        if (rep || c <= L) begin
          e.wv = 1'b1; e.busy = 1'b1;
          e.idx = 5'((c - 1) % L);
          e.w = p[4'((c - 1) % L)];
        end else if (c == L + 1) begin
          e.busy = 1'b1; e.done = 1'b1;
        end
        // z high when the four bits in cycles c-4..c-1 were valid and equal
        if (e.busy && c >= 5) begin
          for (int j = c - 4; j <= c - 1; j++)
            if (!(rep || j <= L) || p[4'((j - 1) % L)] != p[4'((c - 2) % L)]) eq = 1'b0;
          e.z = eq;
        end
      end
      q.push_back(e);
    end
  endtask

  // called at a negedge; start is accepted at the following posedge
  task automatic do_start(input logic [15:0] p, input logic [4:0] len, input bit rep);
    start = 1'b1; pattern = p; length = len; repeat_en = rep;
    @(posedge Clock);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", got);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", got);
    end
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    obs_t got, e;
    do_start(16'h000F, 5'd8, 1'b0);
    push_run(16'h000F, 8, 1'b0, 10, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL basic cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_clamp_alt();
    obs_t got, e;
    do_start(16'hAAAA, 5'd0, 1'b0);
    push_run(16'hAAAA, 0, 1'b0, 18, 0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL clamp_alt cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_repeat_abort();
    obs_t got, e;
    do_start(16'h0003, 5'd2, 1'b1);
    push_run(16'h0003, 2, 1'b1, 13, 12);
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL repeat cycle=%0d got=%h exp=%h", c, got, e);
      end
      abort = (c == 12);
    end
  endtask

  task automatic test_abort_restart();
    obs_t got, e;
    do_start(16'h00FF, 5'd8, 1'b0);
    push_run(16'h00FF, 8, 1'b0, 5, 3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL abort cycle=%0d got=%h exp=%h", c, got, e);
      end
      abort = (c == 3);
    end
    do_start(16'h000F, 5'd8, 1'b0);
    push_run(16'h000F, 8, 1'b0, 10, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL abort_restart cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_ignore_start();
    obs_t got, e;
    do_start(16'h0F0F, 5'd8, 1'b0);
    push_run(16'h0F0F, 8, 1'b0, 10, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL ignore_start cycle=%0d got=%h exp=%h", c, got, e);
      end
      start = (c == 3);
      if (c == 3) begin pattern = 16'hFFFF; length = 5'd3; end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    do_start(16'h0F0F, 5'd8, 1'b0);
    push_run(16'h0F0F, 8, 1'b0, 4, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_pre cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
    #2 Resetn = 1'b0;
    #1 got = sample(); checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=0", got);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    do_start(16'h0F0F, 5'd8, 1'b0);
    push_run(16'h0F0F, 8, 1'b0, 10, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_run cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    do_start(16'h0005, 5'd4, 1'b0);
    push_run(16'h0005, 4, 1'b0, 6, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b_first cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
    // first IDLE cycle after DONE; length above WIDTH clamps to 16
    do_start(16'hFF00, 5'd31, 1'b0);
    push_run(16'hFF00, 31, 1'b0, 18, 0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clock);
      e = q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b_second cycle=%0d got=%h exp=%h", c, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_alt();
    test_repeat_abort();
    test_abort_restart();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_pattern_tx.md
# run_pattern_tx

Serial stimulus transmitter for the one-hot run detector used in the Lab1 designs. The detector asserts `z` after four consecutive equal bits on its `w` input; this block is the driving end of that interface. It shifts a programmed bit pattern onto `w`, one bit per clock, LSB first. Alongside the bits it produces `z_exp`, the detector output expected for the stream sent so far, so a board or bench can compare it cycle-for-cycle against the detector's `z`.

## Interface
- `WIDTH`, default 16: pattern register width in bits.
- `LEN_W`, default 5: width of `length` and `bit_idx`. Must satisfy 2^LEN_W > WIDTH.

- `Clock`  in  1: rising-edge clock.
- `Resetn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin transmission. Sampled only in IDLE.
- `pattern`  in  WIDTH: bits to send. Latched on the accepted `start`.
- `length`  in  LEN_W: number of bits to send, latched with `pattern`. A value of 0 or a value above WIDTH is clamped to WIDTH.
- `repeat_en`  in  1: latched with `pattern`. When 1, the pattern wraps around continuously until `abort`.
- `abort`  in  1: stop transmission. Sampled in every state.
- `w`  out  1: serial data bit, registered.
- `w_valid`  out  1: high while `w` carries a pattern bit.
- `busy`  out  1: high in SEND and DONE.
- `done`  out  1: one-cycle pulse after the last bit of a non-repeating run.
- `z_exp`  out  1: expected detector output, registered.
- `bit_idx`  out  LEN_W: index of the bit currently on `w`.

## Operation
- States: IDLE, SEND, DONE. All state and outputs are registered.
- **Reset.** While `Resetn` is low the block is in IDLE and `w`, `w_valid`, `busy`, `done`, `z_exp` and `bit_idx` are all 0. This takes effect immediately, including in the middle of a transmission.
- **IDLE.** `w`=0 and `w_valid`=0.
  - `start`=1 with `abort`=0 latches `pattern`, the clamped `length` and `repeat_en`, clears the run tracker, and moves to SEND.
  - `start` together with `abort` is ignored.
- **SEND.** `w` = `pattern[bit_idx]`, `w_valid`=1. `bit_idx` counts 0 to len−1.
  - At `bit_idx`=len−1: if repeat mode is latched, `bit_idx` returns to 0 and the block stays in SEND. Otherwise it moves to DONE.
- **DONE.** Lasts one cycle: `done`=1, `w_valid`=0, then IDLE.
- **Abort.** `abort`=1 in SEND or DONE returns the block to IDLE at the next edge. `done` does not pulse, and `z_exp` and the run tracker are cleared.
- `start` while busy is ignored.
- **Run tracker.** Holds the previous bit and a run count that saturates at 4 (3 bits). It updates only on valid bits:
  - a bit equal to the previous one increments the count;
  - a different bit, or the first bit of a run, sets the count to 1.
  - The tracker is not reset when a repeating pattern wraps, because the stream is continuous.
- **z_exp.** 1 in the cycle after a valid bit brings the count to 4 or keeps it at 4. This matches the detector, which samples `w` at the edge and updates `z` from it. `z_exp` is forced to 0 in IDLE.

## Timing
- Call the edge that accepts `start` edge 0. Bit 0 is on `w` in cycle 1, and bit k in cycle k+1.
- `busy` rises in cycle 1.
- For a non-repeating run of len bits, the last bit is in cycle len and DONE is cycle len+1. `busy` falls and IDLE begins in cycle len+2.
- `z_exp` lags the 4th equal bit by exactly one cycle. It can therefore be high during the DONE cycle.
- Abort asserted in cycle c gives `w_valid`=0, `busy`=0 and `z_exp`=0 in cycle c+1.
- A new `start` can be accepted in the first IDLE cycle after DONE.

## Test plan
- `pattern`=16'h000F, `length`=8 → `w` = 1,1,1,1,0,0,0,0 in cycles 1–8. `z_exp`=1 only in cycles 5 and 9. `done`=1 in cycle 9. `busy`=0 from cycle 10.
- `pattern`=16'hAAAA, `length`=0 (clamped to 16) → 16 alternating bits starting with 0. `z_exp` never goes high. `done` in cycle 17.
- `pattern`=16'h0003, `length`=2, `repeat_en`=1 → continuous ones. `z_exp`=1 from cycle 5 onward and `done` never fires. `abort` in cycle 12 → everything 0 in cycle 13.
- `abort` in cycle 3 of a `length`=8 run → `w_valid`=0 and `busy`=0 in cycle 4, no `done`. `start` in cycle 5 → bit 0 on `w` in cycle 6.
- Drive `Resetn` low mid-SEND → all outputs 0 without waiting for a clock edge. After release, `start` → normal run from bit 0.
- Pulse `start` during SEND with a different `pattern` → ignored, and the original bit sequence completes unchanged.
